// File: rtl/xentry_pkg.sv
// Shared types for the xentry memory subsystem: memory operation codes and
// the data-cache miss-handling controller state encoding.
package xentry_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WRITEBACK    = 3'd1,
    REFILL_SETUP = 3'd2,
    ALLOCATE     = 3'd3,
    INSTALL      = 3'd4
  } dcache_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous
// active-low reset clears it.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Data-cache miss controller: serves hits from IDLE, writes back dirty victims
// and refills lines word-by-word from L2, and keeps hit/miss/writeback stats.
module dcache_controller
  import xentry_pkg::*;
#(
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  memory_operation_e     req_type,
  output logic                  req_fulfilled,
  input  logic                  hit,
  input  logic                  clean_miss,
  input  logic                  dirty_miss,
  input  logic                  counter_done,
  output logic                  flush_mode,
  output logic                  load_mode,
  output logic                  clear_selected_dirty_bit,
  output logic                  clear_selected_valid_bit,
  output logic                  finish_new_line_install,
  output logic                  set_new_l2_block_address,
  output logic                  reset_counter,
  output logic                  decrement_counter,
  output logic                  l2_req_valid,
  output memory_operation_e     l2_req_op,
  input  logic                  l2_fulfilled,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count,
  output logic [STAT_WIDTH-1:0] writeback_count
);

  dcache_state_e state, state_next;
  logic hit_event, miss_event, writeback_event;
  logic [STAT_WIDTH-1:0] hit_count_q, miss_count_q, writeback_count_q;

  // Loads and stores are handled identically; the type only matters to the datapath.
  logic unused_req_type;
  assign unused_req_type = req_type;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next               = state;
    req_fulfilled            = 1'b0;
    flush_mode               = 1'b0;
    load_mode                = 1'b0;
    clear_selected_dirty_bit = 1'b0;
    clear_selected_valid_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    set_new_l2_block_address = 1'b0;
    reset_counter            = 1'b0;
    decrement_counter        = 1'b0;
    l2_req_valid             = 1'b0;
    l2_req_op                = LOAD;
    hit_event                = 1'b0;
    miss_event               = 1'b0;
    writeback_event          = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            req_fulfilled = 1'b1;
            hit_event     = 1'b1;
          end else if (dirty_miss || clean_miss) begin
            set_new_l2_block_address = 1'b1;
            reset_counter            = 1'b1;
            miss_event               = 1'b1;
            state_next               = dirty_miss ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        flush_mode   = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_op    = STORE;
        if (l2_fulfilled) begin
          if (counter_done) begin
            clear_selected_valid_bit = 1'b1;
            clear_selected_dirty_bit = 1'b1;
            writeback_event          = 1'b1;
            state_next               = REFILL_SETUP;
          end else begin
            decrement_counter = 1'b1;
          end
        end
      end
      // The victim is now invalid, so the tag latched here is the request's.
      REFILL_SETUP: begin
        set_new_l2_block_address = 1'b1;
        reset_counter            = 1'b1;
        state_next               = ALLOCATE;
      end
      ALLOCATE: begin
        load_mode    = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_op    = LOAD;
        if (l2_fulfilled) begin
          if (counter_done) begin
            state_next = INSTALL;
          end else begin
            decrement_counter = 1'b1;
          end
        end
      end
      INSTALL: begin
        finish_new_line_install  = 1'b1;
        clear_selected_dirty_bit = 1'b1;
        state_next               = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset is synchronous, so outputs are masked until the edge lands.
    if (!reset) begin
      state_next               = IDLE;
      req_fulfilled            = 1'b0;
      flush_mode               = 1'b0;
      load_mode                = 1'b0;
      clear_selected_dirty_bit = 1'b0;
      clear_selected_valid_bit = 1'b0;
      finish_new_line_install  = 1'b0;
      set_new_l2_block_address = 1'b0;
      reset_counter            = 1'b0;
      decrement_counter        = 1'b0;
      l2_req_valid             = 1'b0;
      l2_req_op                = LOAD;
      hit_event                = 1'b0;
      miss_event               = 1'b0;
      writeback_event          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  sat_counter #(.WIDTH(STAT_WIDTH)) u_hit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_event),
    .count (hit_count_q)
  );

  sat_counter #(.WIDTH(STAT_WIDTH)) u_miss_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_event),
    .count (miss_count_q)
  );

  sat_counter #(.WIDTH(STAT_WIDTH)) u_writeback_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (writeback_event),
    .count (writeback_count_q)
  );

  assign hit_count       = reset ? hit_count_q       : '0;
  assign miss_count      = reset ? miss_count_q      : '0;
  assign writeback_count = reset ? writeback_count_q : '0;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller: hits, clean and dirty
// misses, stalled refills, mid-burst reset and counter saturation.
module tb_dcache_controller;
  import xentry_pkg::*;

  localparam int W = 32;

  // Output vector layout used by outs()
  localparam logic [10:0] O_RF  = 11'h400;
  localparam logic [10:0] O_FM  = 11'h200;
  localparam logic [10:0] O_LM  = 11'h100;
  localparam logic [10:0] O_CD  = 11'h080;
  localparam logic [10:0] O_CV  = 11'h040;
  localparam logic [10:0] O_FIN = 11'h020;
  localparam logic [10:0] O_SA  = 11'h010;
  localparam logic [10:0] O_RC  = 11'h008;
  localparam logic [10:0] O_DEC = 11'h004;
  localparam logic [10:0] O_L2V = 11'h002;
  localparam logic [10:0] O_ST  = 11'h001;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, hit, clean_miss, dirty_miss, counter_done, l2_fulfilled;
  memory_operation_e req_type;
  logic req_fulfilled, flush_mode, load_mode, clear_selected_dirty_bit;
  logic clear_selected_valid_bit, finish_new_line_install;
  logic set_new_l2_block_address, reset_counter, decrement_counter, l2_req_valid;
  memory_operation_e l2_req_op;
  logic [W-1:0] hit_count, miss_count, writeback_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dcache_controller #(.STAT_WIDTH(W)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .req_valid                (req_valid),
    .req_type                 (req_type),
    .req_fulfilled            (req_fulfilled),
    .hit                      (hit),
    .clean_miss               (clean_miss),
    .dirty_miss               (dirty_miss),
    .counter_done             (counter_done),
    .flush_mode               (flush_mode),
    .load_mode                (load_mode),
    .clear_selected_dirty_bit (clear_selected_dirty_bit),
    .clear_selected_valid_bit (clear_selected_valid_bit),
    .finish_new_line_install  (finish_new_line_install),
    .set_new_l2_block_address (set_new_l2_block_address),
    .reset_counter            (reset_counter),
    .decrement_counter        (decrement_counter),
    .l2_req_valid             (l2_req_valid),
    .l2_req_op                (l2_req_op),
    .l2_fulfilled             (l2_fulfilled),
    .hit_count                (hit_count),
    .miss_count               (miss_count),
    .writeback_count          (writeback_count)
  );

  function automatic logic [10:0] outs();
    return {req_fulfilled, flush_mode, load_mode, clear_selected_dirty_bit,
            clear_selected_valid_bit, finish_new_line_install,
            set_new_l2_block_address, reset_counter, decrement_counter,
            l2_req_valid, logic'(l2_req_op)};
  endfunction

  // Advance to just after the next rising edge and apply new inputs.
  task automatic drive(input logic rv, input logic h, input logic cm,
                       input logic dm, input logic lf, input logic cdn);
    @(posedge clk);
    #1;
    req_valid    = rv;
    hit          = h;
    clean_miss   = cm;
    dirty_miss   = dm;
    l2_fulfilled = lf;
    counter_done = cdn;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (outs() !== 11'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=%b", outs(), 11'h000);
    end
    checks++;
    if ({hit_count, miss_count, writeback_count} !== '0) begin
      failures++;
      $display("FAIL reset_counters got=%0d/%0d/%0d want=0/0/0",
               hit_count, miss_count, writeback_count);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 11'h000) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=%b", outs(), 11'h000);
    end
  endtask

  task automatic test_hits();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (outs() !== O_RF) begin
        failures++;
        $display("FAIL hit_cycle%0d got=%b want=%b", i, outs(), O_RF);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hit_count !== 32'd3) begin
      failures++;
      $display("FAIL hit_count got=%0d want=3", hit_count);
    end
  endtask

  task automatic test_priority();
    // All three flags together: hit wins, nothing else starts.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs() !== O_RF) begin
      failures++;
      $display("FAIL prio_hit got=%b want=%b", outs(), O_RF);
    end
    // A hit flag without req_valid does nothing.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (outs() !== 11'h000) begin
      failures++;
      $display("FAIL no_req_idle got=%b want=%b", outs(), 11'h000);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hit_count !== 32'd4 || miss_count !== 32'd0) begin
      failures++;
      $display("FAIL prio_counts got=%0d/%0d want=4/0", hit_count, miss_count);
    end
  endtask

  // Eight LOAD words with L2 answering immediately, INSTALL, then the replay hit.
  task automatic refill_and_replay(input string tag, input int stall);
    logic [10:0] exp;
    int decs = 0;
    for (int w = 0; w < 8; w++) begin
      for (int s = 0; s < stall; s++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (outs() !== (O_LM | O_L2V)) begin
          failures++;
          $display("FAIL %s_stall w=%0d s=%0d got=%b want=%b", tag, w, s, outs(), O_LM | O_L2V);
        end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w == 7);
      @(negedge clk);
      exp = O_LM | O_L2V | ((w != 7) ? O_DEC : 11'h000);
      if (decrement_counter === 1'b1) decs++;
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL %s_load w=%0d got=%b want=%b", tag, w, outs(), exp);
      end
    end
    checks++;
    if (decs !== 7) begin
      failures++;
      $display("FAIL %s_dec_pulses got=%0d want=7", tag, decs);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (outs() !== (O_FIN | O_CD)) begin
      failures++;
      $display("FAIL %s_install got=%b want=%b", tag, outs(), O_FIN | O_CD);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs() !== O_RF) begin
      failures++;
      $display("FAIL %s_replay got=%b want=%b", tag, outs(), O_RF);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clean_miss();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs() !== (O_SA | O_RC)) begin
      failures++;
      $display("FAIL clean_accept got=%b want=%b", outs(), O_SA | O_RC);
    end
    refill_and_replay("clean", 0);
    checks++;
    if (miss_count !== 32'd1 || hit_count !== 32'd5) begin
      failures++;
      $display("FAIL clean_counts miss=%0d hit=%0d want=1/5", miss_count, hit_count);
    end
  endtask

  task automatic test_dirty_miss();
    logic [10:0] exp;
    // dirty_miss outranks clean_miss when both are flagged.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs() !== (O_SA | O_RC)) begin
      failures++;
      $display("FAIL dirty_accept got=%b want=%b", outs(), O_SA | O_RC);
    end
    for (int w = 0; w < 8; w++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w == 7);
      @(negedge clk);
      exp = O_FM | O_L2V | O_ST | ((w != 7) ? O_DEC : (O_CD | O_CV));
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL dirty_store w=%0d got=%b want=%b", w, outs(), exp);
      end
    end
    // l2_fulfilled stays high here and must be ignored.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (outs() !== (O_SA | O_RC)) begin
      failures++;
      $display("FAIL dirty_refill_setup got=%b want=%b", outs(), O_SA | O_RC);
    end
    refill_and_replay("dirty", 0);
    checks++;
    if (writeback_count !== 32'd1 || miss_count !== 32'd2) begin
      failures++;
      $display("FAIL dirty_counts wb=%0d miss=%0d want=1/2", writeback_count, miss_count);
    end
  endtask

  task automatic test_alloc_stall();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs() !== (O_SA | O_RC)) begin
      failures++;
      $display("FAIL stall_accept got=%b want=%b", outs(), O_SA | O_RC);
    end
    refill_and_replay("stalled", 5);
  endtask

  task automatic test_reset_mid_burst();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    // Fourth word of the writeback: reset lands here.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 11'h000) begin
      failures++;
      $display("FAIL midburst_reset_outs got=%b want=%b", outs(), 11'h000);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 11'h000) begin
      failures++;
      $display("FAIL midburst_not_resumed got=%b want=%b", outs(), 11'h000);
    end
    checks++;
    if ({hit_count, miss_count, writeback_count} !== '0) begin
      failures++;
      $display("FAIL midburst_counters got=%0d/%0d/%0d want=0/0/0",
               hit_count, miss_count, writeback_count);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (outs() !== O_RF) begin
      failures++;
      $display("FAIL midburst_post_hit got=%b want=%b", outs(), O_RF);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hit_count !== 32'd1) begin
      failures++;
      $display("FAIL midburst_hit_count got=%0d want=1", hit_count);
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    force dut.u_hit_counter.count = '1;
    #1;
    release dut.u_hit_counter.count;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (hit_count !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL hit_count_saturate got=%h want=ffffffff", hit_count);
    end
  endtask

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_type     = LOAD;
    hit          = 1'b0;
    clean_miss   = 1'b0;
    dirty_miss   = 1'b0;
    counter_done = 1'b0;
    l2_fulfilled = 1'b0;
    test_reset();
    test_hits();
    test_priority();
    req_type = STORE;
    test_clean_miss();
    test_dirty_miss();
    req_type = LOAD;
    test_alloc_stall();
    test_reset_mid_burst();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter STAT_WIDTH, default 32, width of each statistics counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports req_valid  input  1 (pipeline request present) and req_type  input  memory_operation_e (LOAD/STORE).
REQ-005 SHALL have port req_fulfilled  output  1  request completes this cycle.
REQ-006 SHALL have inputs hit, clean_miss, dirty_miss, counter_done (1 each), driven by the datapath.
REQ-007 SHALL have outputs flush_mode, load_mode, clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install, set_new_l2_block_address, reset_counter, decrement_counter (1 each), driving the datapath.
REQ-008 SHALL have ports l2_req_valid  output  1; l2_req_op  output  memory_operation_e; l2_fulfilled  input  1 (L2 word transfer done).
REQ-009 SHALL have outputs hit_count, miss_count, writeback_count  STAT_WIDTH each.

Function
REQ-010 SHALL implement states IDLE, WRITEBACK, REFILL_SETUP, ALLOCATE, INSTALL.
REQ-011 IDLE: req_valid&hit -> req_fulfilled=1 combinationally, stay in IDLE; req_valid&dirty_miss -> set_new_l2_block_address=1, reset_counter=1, go to WRITEBACK; req_valid&clean_miss -> same strobes, go to ALLOCATE.
REQ-012 WRITEBACK: flush_mode=1, l2_req_valid=1, l2_req_op=STORE; l2_fulfilled&!counter_done -> decrement_counter=1; l2_fulfilled&counter_done -> clear_selected_valid_bit=1, clear_selected_dirty_bit=1, go to REFILL_SETUP.
REQ-013 REFILL_SETUP (one cycle): set_new_l2_block_address=1, reset_counter=1, go to ALLOCATE; latches the request tag because the line is now invalid (clean miss).
REQ-014 ALLOCATE: load_mode=1, l2_req_valid=1, l2_req_op=LOAD; l2_fulfilled&!counter_done -> decrement_counter=1; l2_fulfilled&counter_done -> go to INSTALL.
REQ-015 INSTALL (one cycle): finish_new_line_install=1, clear_selected_dirty_bit=1, go to IDLE; the replay then hits.
REQ-016 l2_req_valid SHALL stay high across consecutive words of a burst; each l2_fulfilled pulse completes exactly one word.
REQ-017 l2_fulfilled SHALL be ignored outside WRITEBACK/ALLOCATE.
REQ-018 A miss sequence, once started, SHALL run to INSTALL even if req_valid drops; req_fulfilled SHALL only be asserted from IDLE.
REQ-019 All datapath strobes and l2_req_valid SHALL be 0 unless listed for the current state.
REQ-020 Latency, 8-word line, L2 answering in the same cycle: clean miss fulfilled 11 cycles after request accept; dirty miss 20 cycles.
REQ-021 hit_count SHALL increment on every IDLE hit, including replays.
REQ-022 miss_count SHALL increment on each IDLE clean or dirty miss.
REQ-023 writeback_count SHALL increment on each WRITEBACK->REFILL_SETUP transition.
REQ-024 All statistics counters SHALL saturate at all-ones and not wrap.
REQ-025 hit, clean_miss and dirty_miss asserted together (illegal) SHALL be treated with priority hit > dirty_miss > clean_miss.

Reset
REQ-026 reset low at a clock edge SHALL force IDLE and zero all statistics counters, including mid-burst.
REQ-027 All outputs SHALL be 0 while reset is low, except that l2_req_op SHALL be LOAD.
REQ-028 A burst interrupted by reset SHALL not be resumed.

Structure
REQ-029 dcache_state_e SHALL be added to xentry_pkg; the block SHALL reuse memory_operation_e from that package.
REQ-030 The next-state logic SHALL be one always_comb and the state register one always_ff.
REQ-031 The statistics counters SHALL be instances of a sub-module sat_counter (parameter WIDTH; ports clk, reset, inc, count).

Verification
REQ-032 IDLE, req_valid=1, hit=1 for 3 cycles -> req_fulfilled=1 each cycle, hit_count=3, no L2 request.
REQ-033 Clean miss, l2_fulfilled held high, counter_done on 8th word -> 7 decrement_counter pulses, 8 LOAD cycles, then one finish_new_line_install and req_fulfilled on the 11th cycle; miss_count=1.
REQ-034 Dirty miss with the same L2 -> 8 STORE cycles with flush_mode, valid and dirty cleared, REFILL_SETUP, 8 LOAD cycles, INSTALL; writeback_count=1.
REQ-035 l2_fulfilled stalls 5 cycles per word during ALLOCATE -> l2_req_valid held high throughout, no decrement_counter while stalled.
REQ-036 reset asserted on the 4th word of WRITEBACK -> next cycle IDLE, all outputs 0, counters 0; a following hit is fulfilled normally.
REQ-037 Preload hit_count to all-ones (force), apply one hit -> hit_count stays all-ones.
